// File: rtl/axis_mon_pkg.sv
// Shared types and default sizing for the AXI4-stream rate monitor.
package axis_mon_pkg;
    localparam int NCHAN_DEF    = 16;
    localparam int CNTWIDTH_DEF = 32;
    localparam int WINWIDTH_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN
    } mon_state_e;
endpackage

// File: rtl/axis_rate_mon_if.sv
// Per-channel tvalid/tready taps observed by the rate monitor.
interface axis_rate_mon_if
    import axis_mon_pkg::*;
#(
    parameter int NCHAN = NCHAN_DEF
) ();
    logic [NCHAN-1:0] tvalid;
    logic [NCHAN-1:0] tready;

    modport master (output tvalid, output tready);
    modport slave  (input  tvalid, input  tready);
endinterface

// File: rtl/axis_mon_chan.sv
// One monitored channel: tap register, saturating live counters, snapshots, sticky sat.
module axis_mon_chan
    import axis_mon_pkg::*;
#(
    parameter int CNTWIDTH = CNTWIDTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tvalid,
    input  logic                tready,
    input  logic                cnt_en,
    input  logic                commit,
    input  logic                live_clr,
    input  logic                snap_clr,
    output logic [CNTWIDTH-1:0] beat_cnt,
    output logic [CNTWIDTH-1:0] stall_cnt,
    output logic                sat
);
    logic                tvalid_p1, tready_p1;
    logic [CNTWIDTH-1:0] beat_live, stall_live;
    logic [CNTWIDTH-1:0] beat_nxt, stall_nxt;
    logic                beat_inc, stall_inc, sat_hit;

    function automatic logic [CNTWIDTH-1:0] sat_add(input logic [CNTWIDTH-1:0] a,
                                                    input logic inc);
        if (inc && (a != '1)) return a + CNTWIDTH'(1);
        return a;
    endfunction

    assign beat_inc  = cnt_en & tvalid_p1 & tready_p1;
    assign stall_inc = cnt_en & ~tvalid_p1 & tready_p1;
    assign beat_nxt  = sat_add(beat_live, beat_inc);
    assign stall_nxt = sat_add(stall_live, stall_inc);
    // sat flags any counting cycle that leaves a counter pinned at all-ones
    assign sat_hit   = (beat_inc && (beat_nxt == '1)) || (stall_inc && (stall_nxt == '1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tvalid_p1  <= 1'b0;
            tready_p1  <= 1'b0;
            beat_live  <= '0;
            stall_live <= '0;
            beat_cnt   <= '0;
            stall_cnt  <= '0;
            sat        <= 1'b0;
        end else begin
            // p1: taps registered once, counting works on the delayed copy
            tvalid_p1 <= tvalid;
            tready_p1 <= tready;

            if (live_clr || commit) begin
                beat_live  <= '0;
                stall_live <= '0;
            end else if (cnt_en) begin
                beat_live  <= beat_nxt;
                stall_live <= stall_nxt;
            end

            if (commit) begin
                beat_cnt  <= beat_nxt;
                stall_cnt <= stall_nxt;
            end else if (snap_clr) begin
                beat_cnt  <= '0;
                stall_cnt <= '0;
            end

            if (snap_clr || live_clr) sat <= 1'b0;
            else if (sat_hit)         sat <= 1'b1;
        end
    end
endmodule

// File: rtl/axis_rate_mon.sv
// Windowed beat/underrun rate monitor over NCHAN AXI4-stream taps.
module axis_rate_mon
    import axis_mon_pkg::*;
#(
    parameter int NCHAN    = NCHAN_DEF,
    parameter int CNTWIDTH = CNTWIDTH_DEF,
    parameter int WINWIDTH = WINWIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    axis_rate_mon_if.slave            taps,
    input  logic [WINWIDTH-1:0]       win_len,
    input  logic                      stb_start,
    input  logic                      stb_stop,
    input  logic                      stb_clear,
    input  logic                      trigmode,
    input  logic                      trig,
    input  logic                      continuous,
    output logic [NCHAN*CNTWIDTH-1:0] beat_cnt,
    output logic [NCHAN*CNTWIDTH-1:0] stall_cnt,
    output logic [NCHAN-1:0]          sat,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               nwin
);
    mon_state_e          state, state_nxt;
    logic [WINWIDTH-1:0] wlen_lat, wrem;
    logic                cnt_en, commit, start_ok, win_end;

    function automatic logic [WINWIDTH-1:0] clamp_len(input logic [WINWIDTH-1:0] len);
        return (len == '0) ? WINWIDTH'(1) : len;
    endfunction

    assign win_end = (wrem == WINWIDTH'(1));
    assign busy    = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        cnt_en    = 1'b0;
        commit    = 1'b0;
        start_ok  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (stb_start && !stb_stop) begin
                    start_ok  = 1'b1;
                    state_nxt = trigmode ? ST_ARMED : ST_RUN;
                end
            end
            ST_ARMED, ST_RUN: begin
                if (stb_stop) begin
                    state_nxt = ST_IDLE;
                end else if (state == ST_RUN || trig) begin
                    // the trigger cycle itself is the first counted cycle
                    cnt_en    = 1'b1;
                    state_nxt = ST_RUN;
                    if (win_end) begin
                        commit = 1'b1;
                        if (!continuous) state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wlen_lat <= '0;
            wrem     <= '0;
            done     <= 1'b0;
            nwin     <= '0;
        end else begin
            state <= state_nxt;
            done  <= commit;
            if (start_ok) begin
                wlen_lat <= clamp_len(win_len);
                wrem     <= clamp_len(win_len);
            end else if (cnt_en) begin
                wrem <= commit ? wlen_lat : wrem - WINWIDTH'(1);
            end
            if (stb_clear)   nwin <= '0;
            else if (commit) nwin <= nwin + 16'd1;
        end
    end

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        axis_mon_chan #(.CNTWIDTH(CNTWIDTH)) u_chan (
            .clk       (clk),
            .reset     (reset),
            .tvalid    (taps.tvalid[i]),
            .tready    (taps.tready[i]),
            .cnt_en    (cnt_en),
            .commit    (commit),
            .live_clr  (start_ok),
            .snap_clr  (stb_clear),
            .beat_cnt  (beat_cnt[i*CNTWIDTH +: CNTWIDTH]),
            .stall_cnt (stall_cnt[i*CNTWIDTH +: CNTWIDTH]),
            .sat       (sat[i])
        );
    end
endmodule

// File: tb/tb_axis_rate_mon.sv
// Scoreboard bench: two monitors (32-bit and 4-bit counters) share one set of taps.
`timescale 1ns/1ps
module tb_axis_rate_mon;
    import axis_mon_pkg::*;

    localparam int NCH   = 4;
    localparam int CWA   = 32;
    localparam int CWB   = 4;
    localparam int WW    = 24;
    localparam int HMAX  = 16384;
    localparam int CMAXB = (1 << CWB) - 1;

    typedef struct packed {
        logic [31:0]           cyc;
        logic [NCH-1:0][31:0]  beat;
        logic [NCH-1:0][31:0]  stall;
        logic [NCH-1:0]        sat_b;
        logic [15:0]           nwin;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          stb_start = 1'b0, stb_stop = 1'b0, stb_clear = 1'b0;
    logic          trigmode = 1'b0, trig = 1'b0, continuous = 1'b0;
    logic [WW-1:0] win_len = '0;

    logic [NCH*CWA-1:0] beat_a, stall_a;
    logic [NCH*CWB-1:0] beat_b, stall_b;
    logic [NCH-1:0]     sat_a, sat_b;
    logic               busy_a, busy_b, done_a, done_b;
    logic [15:0]        nwin_a, nwin_b;

    axis_rate_mon_if #(.NCHAN(NCH)) bus ();

    axis_rate_mon #(.NCHAN(NCH), .CNTWIDTH(CWA), .WINWIDTH(WW)) u_dut_a (
        .clk(clk), .reset(reset), .taps(bus), .win_len(win_len),
        .stb_start(stb_start), .stb_stop(stb_stop), .stb_clear(stb_clear),
        .trigmode(trigmode), .trig(trig), .continuous(continuous),
        .beat_cnt(beat_a), .stall_cnt(stall_a), .sat(sat_a),
        .busy(busy_a), .done(done_a), .nwin(nwin_a)
    );

    axis_rate_mon #(.NCHAN(NCH), .CNTWIDTH(CWB), .WINWIDTH(WW)) u_dut_b (
        .clk(clk), .reset(reset), .taps(bus), .win_len(win_len),
        .stb_start(stb_start), .stb_stop(stb_stop), .stb_clear(stb_clear),
        .trigmode(trigmode), .trig(trig), .continuous(continuous),
        .beat_cnt(beat_b), .stall_cnt(stall_b), .sat(sat_b),
        .busy(busy_b), .done(done_b), .nwin(nwin_b)
    );

    // reference model state: tap history per clock edge plus window bookkeeping
    logic [NCH-1:0] hv [HMAX];
    logic [NCH-1:0] hr [HMAX];
    int             cyc = 0;
    int             mode = 0;
    int             n_cmp = 0, n_bad = 0;
    logic [NCH-1:0] sat_m = '0;
    int             nwin_m = 0;
    exp_t           last_exp = '0;
    exp_t           q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] sat_b_of(input logic [31:0] v);
        return (v > 32'(CMAXB)) ? 64'(CMAXB) : 64'(v);
    endfunction

    // counted edge k uses the taps that were present at edge k-1
    function automatic int tap_sum(input int ch, input int f, input int e, input bit stall);
        int s = 0;
        for (int k = f; k <= e; k++) begin
            if (stall) begin
                if (hr[k-1][ch] && !hv[k-1][ch]) s++;
            end else begin
                if (hr[k-1][ch] && hv[k-1][ch]) s++;
            end
        end
        return s;
    endfunction

    task automatic step();
        logic [NCH-1:0] v, r;
        v = NCH'($urandom);
        r = NCH'($urandom);
        if (mode == 1) begin
            v = NCH'(1);
            r = NCH'(3);
        end else if (mode == 2) begin
            v[0] = 1'b1;
            r[0] = 1'b1;
        end
        bus.tvalid = v;
        bus.tready = r;
        hv[cyc] = v;
        hr[cyc] = r;
        @(posedge clk);
        cyc++;
        #1;
        stb_start = 1'b0;
        stb_stop  = 1'b0;
        stb_clear = 1'b0;
    endtask

    task automatic compare_exp(input string tag, input exp_t x);
        for (int ch = 0; ch < NCH; ch++) begin
            check({tag, "_beat_a"},  64'(beat_a[ch*CWA +: CWA]),  64'(x.beat[ch]));
            check({tag, "_stall_a"}, 64'(stall_a[ch*CWA +: CWA]), 64'(x.stall[ch]));
            check({tag, "_beat_b"},  64'(beat_b[ch*CWB +: CWB]),  sat_b_of(x.beat[ch]));
            check({tag, "_stall_b"}, 64'(stall_b[ch*CWB +: CWB]), sat_b_of(x.stall[ch]));
        end
        check({tag, "_sat_a"},  64'(sat_a),  64'(0));
        check({tag, "_sat_b"},  64'(sat_b),  64'(x.sat_b));
        check({tag, "_nwin_a"}, 64'(nwin_a), 64'(x.nwin));
        check({tag, "_nwin_b"}, 64'(nwin_b), 64'(x.nwin));
    endtask

    task automatic push_window(input int f, input int e, input bit clr_here);
        exp_t x;
        x = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            x.beat[ch]  = 32'(tap_sum(ch, f, e, 1'b0));
            x.stall[ch] = 32'(tap_sum(ch, f, e, 1'b1));
            if (x.beat[ch] >= 32'(CMAXB) || x.stall[ch] >= 32'(CMAXB)) sat_m[ch] = 1'b1;
        end
        nwin_m = (nwin_m + 1) & 16'hffff;
        if (clr_here) begin
            nwin_m = 0;
            sat_m  = '0;
        end
        x.sat_b = sat_m;
        x.nwin  = 16'(nwin_m);
        x.cyc   = 32'(e + 1);
        q.push_back(x);
        last_exp = x;
    endtask

    task automatic run_window(input int len, input bit tm, input int tdly,
                              input int nw, input bit clr_last);
        int L, f, e;
        L          = (len == 0) ? 1 : len;
        win_len    = WW'(len);
        trigmode   = tm;
        continuous = (nw > 1);
        trig       = 1'b0;
        stb_start  = 1'b1;
        step();
        sat_m   = '0;
        win_len = WW'($urandom_range(0, 60));
        if (tm) begin
            for (int i = 1; i < tdly; i++) step();
            check("armed_busy", 64'(busy_a), 64'(1));
            trig = 1'b1;
        end
        f = cyc;
        for (int w = 0; w < nw; w++) begin
            e = f + L * (w + 1) - 1;
            while (cyc < e) begin
                if (cyc == f + 1) stb_start = 1'b1;
                step();
            end
            if (w == nw - 1) begin
                continuous = 1'b0;
                if (clr_last) stb_clear = 1'b1;
            end
            step();
            push_window(e - L + 1, e, clr_last && (w == nw - 1));
        end
        trig = 1'b0;
        step();
        step();
        check("idle_after_win", 64'(busy_a), 64'(0));
    endtask

    task automatic run_stop(input int len, input int k);
        int f;
        win_len    = WW'(len);
        trigmode   = 1'b0;
        continuous = 1'b0;
        stb_start  = 1'b1;
        step();
        f = cyc;
        while (cyc < f + k - 1) step();
        stb_stop = 1'b1;
        step();
        sat_m = '0;
        for (int ch = 0; ch < NCH; ch++)
            if (tap_sum(ch, f, f + k - 2, 1'b0) >= CMAXB || tap_sum(ch, f, f + k - 2, 1'b1) >= CMAXB)
                sat_m[ch] = 1'b1;
        last_exp.sat_b = sat_m;
        repeat (3) step();
        check("stop_busy", 64'(busy_a), 64'(0));
        compare_exp("stop_snap", last_exp);
    endtask

    // scoreboard monitor: every done pulse must match the oldest expected window
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (done_a || done_b) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_done: done_a=%0d done_b=%0d at cycle %0d, expected none",
                             done_a, done_b, cyc);
                end else begin
                    x = q.pop_front();
                    check("done_a", 64'(done_a), 64'(1));
                    check("done_b", 64'(done_b), 64'(1));
                    check("done_cycle", 64'(cyc), 64'(x.cyc));
                    compare_exp("win", x);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.tvalid = '0;
        bus.tready = '0;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        check("rst_busy", 64'(busy_a), 64'(0));
        check("rst_done", 64'(done_a), 64'(0));
        compare_exp("rst", last_exp);

        mode = 1;
        run_window(100, 1'b0, 0, 1, 1'b0);
        mode = 2;
        run_window(10, 1'b0, 0, 5, 1'b0);
        run_window(20, 1'b1, 50, 1, 1'b0);
        run_window(40, 1'b0, 0, 1, 1'b0);

        stb_clear = 1'b1;
        step();
        last_exp = '0;
        sat_m    = '0;
        nwin_m   = 0;
        compare_exp("clear", last_exp);

        mode = 0;
        run_window(30, 1'b0, 0, 1, 1'b0);
        run_stop(100, 30);
        run_stop(20, 20);

        win_len   = WW'(100);
        trigmode  = 1'b0;
        stb_start = 1'b1;
        step();
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        last_exp = '0;
        sat_m    = '0;
        nwin_m   = 0;
        check("rst_mid_busy", 64'(busy_a), 64'(0));
        compare_exp("rst_mid", last_exp);
        repeat (3) step();

        run_window(0, 1'b0, 0, 1, 1'b0);
        run_window(12, 1'b0, 0, 1, 1'b1);

        for (int it = 0; it < 8; it++) begin
            int nw;
            mode = (it % 3 == 0) ? 2 : 0;
            nw   = $urandom_range(1, 3);
            run_window($urandom_range(0, 24), 1'($urandom_range(0, 1)),
                       $urandom_range(1, 8), nw, 1'b0);
        end
        repeat (4) step();

        check("queue_empty", 64'(q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
